// File: rtl/key_pkg.sv
// Shared types and constants for the pushbutton debounce / step counter block.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM_PRESS = 2'd1,
    HELD      = 2'd2,
    ARM_REL   = 2'd3
  } deb_state_e;

  // Active-low segments, bit order a..g left to right (HEX[0] = a).
  localparam logic [0:6] SEG7_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchroniser, 4-state debounce FSM, one-cycle press strobe.
//
// state     | meaning
// IDLE      | stable released
// ARM_PRESS | low seen, counting stable low samples
// HELD      | stable pressed
// ARM_REL   | high seen, counting stable high samples
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic key,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // The first differing sample loads 1, so the last accepted sample sees D-1.
  localparam logic [CW-1:0] CNT_TC  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    sync_q;
  logic          smp;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_d;

  assign smp = sync_q[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!smp) begin
          state_d = ARM_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      ARM_PRESS: begin
        if (smp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (smp) begin
          state_d = ARM_REL;
          cnt_d   = CNT_ONE;
        end
      end
      ARM_REL: begin
        if (!smp) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_debounce_counter.sv
// Two debounced pushbuttons stepping a modulo 0..MAX_COUNT counter, with registered HEX digit.
module key_debounce_counter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_COUNT       = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       KEY_UP,
  input  logic       KEY_DN,
  input  logic       CLR,
  output logic [3:0] COUNT,
  output logic [0:6] HEX,
  output logic       UP_PULSE,
  output logic       DN_PULSE
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_COUNT);

  logic [3:0] count_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .CLK   (CLK),
    .RST_N (RST_N),
    .key   (KEY_UP),
    .pulse (UP_PULSE)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .CLK   (CLK),
    .RST_N (RST_N),
    .key   (KEY_DN),
    .pulse (DN_PULSE)
  );

  // Simultaneous up and down strobes cancel.
  always_comb begin
    count_d = COUNT;
    if (CLR) begin
      count_d = '0;
    end else if (UP_PULSE && DN_PULSE) begin
      count_d = COUNT;
    end else if (UP_PULSE) begin
      count_d = (COUNT == MAX_CNT) ? 4'd0 : COUNT + 4'd1;
    end else if (DN_PULSE) begin
      count_d = (COUNT == 4'd0) ? MAX_CNT : COUNT - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COUNT <= '0;
      HEX   <= SEG7_LUT[0];
    end else begin
      COUNT <= count_d;
      HEX   <= SEG7_LUT[count_d];
    end
  end

endmodule
